// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters to a single UART transmitter.
// Bursts lock the owner until a byte marked last completes; a watchdog releases stuck owners.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TIMEOUT_CLKS = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_data,
    input  logic [NUM_REQ-1:0]   i_last,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_Tx_Ready,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_timeout
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CLKS);
    localparam logic [WdW-1:0]  WdLimit = WdW'(TIMEOUT_CLKS - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitDone,
        StHold
    } state_t;

    state_t              state_q, state_d;
    logic [IdxW-1:0]     last_winner_q, last_winner_d;
    logic                last_q, last_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                tx_ready_q, tx_ready_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                timeout_q, timeout_d;

    logic                rr_found;
    logic [IdxW-1:0]     rr_idx;
    logic                load;
    logic [IdxW-1:0]     load_idx;
    logic [NUM_REQ-1:0]  load_oh;

    // Requester index offs+1 places after base, wrapping at NUM_REQ.
    function automatic logic [IdxW-1:0] rr_index(input logic [IdxW-1:0] base,
                                                 input int unsigned offs);
        int unsigned sum;
        sum = 32'(base) + offs + 32'd1;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IdxW'(sum);
    endfunction

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && i_req[rr_index(last_winner_q, i)]) begin
                rr_found = 1'b1;
                rr_idx   = rr_index(last_winner_q, i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        last_d        = last_q;
        wd_d          = wd_q;
        ack_d         = '0;
        grant_d       = grant_q;
        tx_ready_d    = 1'b0;
        tx_byte_d     = tx_byte_q;
        timeout_d     = 1'b0;
        load          = 1'b0;
        load_idx      = rr_idx;
        load_oh       = '0;

        unique case (state_q)
            StIdle: begin
                if (rr_found && !i_Tx_Active) begin
                    load     = 1'b1;
                    load_idx = rr_idx;
                end
            end
            StSend: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // A completing frame beats a simultaneous watchdog expiry.
                if (i_Tx_Done) begin
                    if (last_q) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end else begin
                        state_d = StHold;
                    end
                end else if (wd_q == WdLimit) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = StIdle;
                end
            end
            StHold: begin
                if (i_req[last_winner_q] && !i_Tx_Active) begin
                    load     = 1'b1;
                    load_idx = last_winner_q;
                end else if (wd_q == WdLimit) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            load_oh[load_idx] = 1'b1;
            state_d       = StSend;
            last_winner_d = load_idx;
            last_d        = i_last[load_idx];
            tx_byte_d     = i_data[8*load_idx +: 8];
            grant_d       = load_oh;
            ack_d         = load_oh;
            tx_ready_d    = 1'b1;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if ((state_q == StWaitDone || state_q == StHold) && wd_q != WdLimit) begin
            wd_d = wd_q + WdW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            last_winner_q <= LastIdx;
            last_q        <= 1'b1;
            wd_q          <= '0;
            ack_q         <= '0;
            grant_q       <= '0;
            tx_ready_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            last_q        <= last_d;
            wd_q          <= wd_d;
            ack_q         <= ack_d;
            grant_q       <= grant_d;
            tx_ready_q    <= tx_ready_d;
            tx_byte_q     <= tx_byte_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_grant    = grant_q;
    assign o_Tx_Ready = tx_ready_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked each cycle against a transaction-level model of owner, frame and watchdog age.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           tx_ready;
    logic [7:0]     tx_byte;
    logic           tx_active;
    logic           tx_done;
    logic           timeout;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CLKS(T)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (req),
        .i_data     (data),
        .i_last     (last),
        .o_ack      (ack),
        .o_grant    (grant),
        .o_Tx_Ready (tx_ready),
        .o_Tx_Byte  (tx_byte),
        .i_Tx_Active(tx_active),
        .i_Tx_Done  (tx_done),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the link, whether a frame is out, and how long we have waited.
    int   m_lw, m_owner, m_age;
    bit   m_strobe, m_inflight, m_end;
    logic [N-1:0] e_ack, e_grant;
    logic         e_ready, e_to;
    logic [7:0]   e_byte;

    // Transmitter stand-in.
    int tx_cnt = 0;
    int tx_len = 3;
    bit tx_drop_all = 1'b0;
    bit tx_drop_now = 1'b0;

    logic [7:0] got[$];
    logic [7:0] exp_b[5];
    logic [7:0] exp_c[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_grant(input int w);
        m_owner    = w;
        m_lw       = w;
        m_strobe   = 1'b1;
        m_end      = last[w];
        e_byte     = data[8*w +: 8];
        e_grant    = '0;
        e_grant[w] = 1'b1;
        e_ack      = e_grant;
        e_ready    = 1'b1;
    endtask

    task automatic model_expire();
        e_to       = 1'b1;
        m_owner    = -1;
        m_inflight = 1'b0;
        e_grant    = '0;
    endtask

    task automatic model_step();
        e_ack   = '0;
        e_ready = 1'b0;
        e_to    = 1'b0;
        if (!reset_n) begin
            m_lw = N - 1; m_owner = -1; m_strobe = 0; m_inflight = 0; m_end = 1; m_age = 0;
            e_grant = '0;
            e_byte  = 8'h00;
        end else if (m_strobe) begin
            m_strobe = 1'b0; m_inflight = 1'b1; m_age = 0;
        end else if (m_inflight) begin
            if (tx_done) begin
                m_inflight = 1'b0;
                m_age      = 0;
                if (m_end) begin
                    m_owner = -1;
                    e_grant = '0;
                end
            end else if (m_age == T - 1) begin
                model_expire();
            end else begin
                m_age++;
            end
        end else if (m_owner >= 0) begin
            if (req[m_owner] && !tx_active) model_grant(m_owner);
            else if (m_age == T - 1) model_expire();
            else m_age++;
        end else if (!tx_active) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_lw + k) % N;
                if (req[c]) begin
                    model_grant(c);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("ack", 32'(ack), 32'(e_ack));
        check("grant", 32'(grant), 32'(e_grant));
        check("tx_ready", 32'(tx_ready), 32'(e_ready));
        check("tx_byte", 32'(tx_byte), 32'(e_byte));
        check("timeout", 32'(timeout), 32'(e_to));
    endtask

    task automatic tx_step();
        tx_done = 1'b0;
        if (e_ready) begin
            tx_cnt      = tx_len;
            tx_active   = 1'b1;
            tx_drop_now = tx_drop_all;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_active = 1'b0;
                tx_done   = !tx_drop_now;
            end
        end else begin
            tx_active = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; last = '0; data = '0;
        tx_done = 1'b0; tx_active = 1'b0; tx_cnt = 0; tx_drop_all = 1'b0; tx_len = 3;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int   ack2_at, to_at, bi;
        bit   to_seen, ack_seen, to_first;
        logic [N-1:0] first_ack;
        logic [7:0] burst[3];

        exp_b = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h01};
        exp_c = '{8'hAA, 8'hAB, 8'h88, 8'h21};
        burst = '{8'hAA, 8'hAB, 8'h88};

        // Single byte, plus reset values.
        do_reset();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ready", 32'(tx_ready), 32'h0);
        check("rst_byte", 32'(tx_byte), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        req = 4'b0001; data[7:0] = 8'h55; last = 4'b0001;
        tick();
        check("single_ready", 32'(tx_ready), 32'h1);
        check("single_byte", 32'(tx_byte), 32'h55);
        check("single_ack", 32'(ack), 32'b0001);
        check("single_grant", 32'(grant), 32'b0001);
        req = '0;
        tx_step();
        for (int i = 0; i < 8; i++) begin
            tick();
            tx_step();
        end
        check("single_grant_end", 32'(grant), 32'h0);

        // Round robin over four continuous requesters.
        do_reset();
        req = '1; data = {8'h32, 8'h22, 8'h10, 8'h01}; last = '1;
        got.delete();
        for (int i = 0; i < 100 && got.size() < 5; i++) begin
            tick();
            if (tx_ready) got.push_back(tx_byte);
            tx_step();
        end
        check("rr_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++) check("rr_order", 32'(got[i]), 32'(exp_b[i]));

        // Burst lock: requester 1 holds the link until its last byte.
        do_reset();
        req = 4'b0110; data = {8'h00, 8'h21, 8'hAA, 8'h00}; last = 4'b0100;
        got.delete();
        ack2_at = -1;
        bi = 0;
        for (int i = 0; i < 120 && got.size() < 4; i++) begin
            tick();
            if (tx_ready) got.push_back(tx_byte);
            if (ack[2] && ack2_at < 0) ack2_at = got.size();
            if (ack[1]) begin
                bi++;
                if (bi < 3) begin
                    data[15:8] = burst[bi];
                    last[1]    = (bi == 2);
                end else begin
                    req[1] = 1'b0;
                end
            end
            if (ack[2]) req[2] = 1'b0;
            tx_step();
        end
        check("burst_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size(); i++) check("burst_order", 32'(got[i]), 32'(exp_c[i]));
        check("burst_ack2_strobe", 32'(ack2_at), 32'd4);

        // Watchdog in WAIT_DONE: the transmitter never reports completion.
        do_reset();
        tx_drop_all = 1'b1;
        req = 4'b0001; data[7:0] = 8'h5A; last = 4'b0001;
        tick();
        check("wd_ready", 32'(tx_ready), 32'h1);
        req = '0;
        tx_step();
        tick();
        tx_step();
        to_at = -1;
        for (int i = 1; i <= 3 * T && to_at < 0; i++) begin
            tick();
            if (timeout) to_at = i;
            tx_step();
        end
        check("wd_latency", 32'(to_at), 32'(T));
        check("wd_grant", 32'(grant), 32'h0);
        tick();
        check("wd_pulse_len", 32'(timeout), 32'h0);
        tx_step();
        tx_drop_all = 1'b0;

        // HOLD abandon: requester 3 leaves a burst open and walks away.
        do_reset();
        req = 4'b1000; data = {8'h77, 24'h0}; last = 4'b0000;
        tick();
        check("hold_ack3", 32'(ack), 32'b1000);
        req = 4'b0011; data[15:0] = 16'h1E0E; last = 4'b0011;
        tx_step();
        to_seen = 1'b0; ack_seen = 1'b0; to_first = 1'b0; first_ack = '0;
        for (int i = 0; i < 6 * T && !ack_seen; i++) begin
            tick();
            if (timeout) to_seen = 1'b1;
            if (ack != '0) begin
                ack_seen  = 1'b1;
                first_ack = ack;
                to_first  = to_seen;
            end
            tx_step();
        end
        check("hold_next_ack", 32'(first_ack), 32'b0001);
        check("hold_timeout_first", 32'(to_first), 32'h1);

        // Reset while a frame is in flight restores requester 0 priority.
        do_reset();
        tx_len = 6;
        req = 4'b0100; data[23:16] = 8'h42; last = 4'b0100;
        tick();
        check("rstmid_ack2", 32'(ack), 32'b0100);
        req = '0;
        tx_step();
        tick(); tx_step();
        tick(); tx_step();
        reset_n = 1'b0;
        req = '1; data = 32'h44332211; last = '1;
        tick();
        check("rstmid_ack", 32'(ack), 32'h0);
        check("rstmid_grant", 32'(grant), 32'h0);
        check("rstmid_ready", 32'(tx_ready), 32'h0);
        check("rstmid_byte", 32'(tx_byte), 32'h0);
        check("rstmid_timeout", 32'(timeout), 32'h0);
        reset_n = 1'b1; tx_cnt = 0; tx_active = 1'b0; tx_done = 1'b0; tx_len = 3;
        first_ack = '0;
        for (int i = 0; i < 10 && first_ack == '0; i++) begin
            tick();
            first_ack = ack;
            tx_step();
        end
        check("rstmid_first_grant", 32'(first_ack), 32'b0001);

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            reset_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < N; k++) begin
                if (e_ack[k] || !req[k]) begin
                    data[8*k +: 8] = 8'($urandom);
                    last[k]        = ($urandom_range(0, 2) != 0);
                end
                if (e_ack[k]) req[k] = ($urandom_range(0, 1) == 1);
                else if (!req[k]) req[k] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 40) == 0) req[k] = 1'b0;
            end
            tx_len      = $urandom_range(1, 5);
            tx_drop_all = ($urandom_range(0, 9) == 0);
            tx_step();
            if (tx_cnt == 0 && !tx_done) begin
                if ($urandom_range(0, 30) == 0) tx_done = 1'b1;
                else if ($urandom_range(0, 20) == 0) tx_active = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CLKS, default 4096, watchdog limit in clk cycles (legal 16..65535).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port i_req, input, NUM_REQ, per-requester byte-valid, held until the matching o_ack.
REQ-006 The block SHALL have port i_data, input, 8*NUM_REQ, requester k byte in bits [8k+7:8k].
REQ-007 The block SHALL have port i_last, input, NUM_REQ, marks the presented byte as end of burst.
REQ-008 The block SHALL have port o_ack, output, NUM_REQ, one-cycle pulse when requester byte is taken.
REQ-009 The block SHALL have port o_grant, output, NUM_REQ, one-hot current owner; zero when no owner.
REQ-010 The block SHALL have port o_Tx_Ready, output, 1, one-cycle start strobe to the UART transmitter.
REQ-011 The block SHALL have port o_Tx_Byte, output, 8, byte to transmit, stable from strobe until i_Tx_Done.
REQ-012 The block SHALL have port i_Tx_Active, input, 1, transmitter busy.
REQ-013 The block SHALL have port i_Tx_Done, input, 1, one-cycle frame-complete pulse from the transmitter.
REQ-014 The block SHALL have port o_timeout, output, 1, one-cycle pulse on watchdog expiry.

Function
REQ-015 The block SHALL implement FSM states IDLE, SEND, WAIT_DONE, HOLD.
REQ-016 IDLE: when any i_req=1 and i_Tx_Active=0, the block SHALL pick the winner round-robin, searching from (last_winner+1) mod NUM_REQ upward, and enter SEND next edge.
REQ-017 The winner's i_data and i_last SHALL be registered on the IDLE->SEND (or HOLD->SEND) edge; o_grant becomes the winner's one-hot on the same edge.
REQ-018 SEND SHALL last exactly one cycle, asserting o_Tx_Ready=1 and o_ack[winner]=1, then enter WAIT_DONE; latency from i_req sampled in IDLE to strobe is 1 cycle.
REQ-019 last_winner SHALL update to the winner only on entry to SEND.
REQ-020 WAIT_DONE on i_Tx_Done=1: registered last=1 -> IDLE with o_grant=0; last=0 -> HOLD with o_grant unchanged.
REQ-021 HOLD: only the owner is served; owner i_req=1 and i_Tx_Active=0 -> SEND next edge with owner's new byte; other requesters SHALL receive no ack.
REQ-022 A watchdog counter SHALL clear on every state entry and increment each cycle in WAIT_DONE or HOLD; on reaching TIMEOUT_CLKS-1 the block SHALL pulse o_timeout, clear o_grant, and enter IDLE.
REQ-023 Watchdog width SHALL be clog2(TIMEOUT_CLKS) bits; it SHALL not wrap.
REQ-024 i_Tx_Done and watchdog expiry in the same cycle: i_Tx_Done SHALL win, no o_timeout.
REQ-025 i_Tx_Done seen outside WAIT_DONE SHALL be ignored.
REQ-026 Requester deasserting i_req before ack in IDLE SHALL simply not be selected; no ack is ever issued to a requester with i_req=0 at selection.
REQ-027 o_Tx_Ready SHALL never assert while i_Tx_Active=1 at selection time, and never on two consecutive cycles.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 With reset_n=0 at a clk edge, state SHALL become IDLE, last_winner=NUM_REQ-1 (requester 0 first priority), watchdog=0, registered last=1.
REQ-030 Reset values: o_ack=0, o_grant=0, o_Tx_Ready=0, o_Tx_Byte=8'h00, o_timeout=0.
REQ-031 Reset mid-operation (any state) SHALL abort without any further ack or strobe; an in-flight transmission is not tracked after reset.

Verification
REQ-032 Single byte: i_req[0]=1, data 8'h55, last=1 -> one cycle later o_Tx_Ready=1, o_Tx_Byte=8'h55, o_ack=4'b0001; after i_Tx_Done -> IDLE, o_grant=0.
REQ-033 Round robin: all four requesters continuously request single bytes 8'h01,8'h10,8'h22,8'h32 (last=1) -> strobes carry 01,10,22,32,01 in that order.
REQ-034 Burst lock: requester 1 sends 8'hAA,8'hAB,8'h88 (last on third) while requester 2 holds 8'h21 -> order AA,AB,88,21; o_ack[2]=0 until burst ends.
REQ-035 Watchdog: strobe issued, i_Tx_Done never asserted -> o_timeout pulse exactly TIMEOUT_CLKS cycles after WAIT_DONE entry, o_grant=0, IDLE.
REQ-036 HOLD abandon: requester 3 sends 8'h77 with last=0 then drops i_req -> o_timeout after TIMEOUT_CLKS in HOLD, then requester 0 served.
REQ-037 Reset in WAIT_DONE: reset_n=0 one cycle -> all outputs at reset values next edge; first subsequent grant goes to requester 0 when all request.
